// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: RV32I opcode, funct3
// and funct7 constants (common with the CPU control decode), the symbolic
// operation codes, the loader FSM states and the immediate range limits.
package instr_encoder_loader_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Signed immediate limits (branch/jump limits are byte offsets)
    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
    localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_ADDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_JAL  = 4'd9,
        OP_JALR = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding encoded words until instruction memory takes
// them. Pointers carry one extra wrap bit so full and empty are unambiguous.
module instr_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for storage and pointers; writes ignored when full, reads when empty
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage is cleared on reset so the memory data port reads zero afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic RV32I instruction fields into machine words and streams
// them into instruction memory at consecutive word addresses from a base.
// Bundles with an illegal op or an out-of-range immediate are consumed but
// dropped, and flag a sticky error for the rest of the session.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [31:0]      iBaseAddr,
    input  logic             iStop,
    input  logic             iValid,
    output logic             oReady,
    input  logic [3:0]       iOp,
    input  logic [4:0]       iRd,
    input  logic [4:0]       iRs1,
    input  logic [4:0]       iRs2,
    input  logic [31:0]      iImm,
    output logic             oMemWrite,
    input  logic             iMemReady,
    output logic [31:0]      oMemAddr,
    output logic [31:0]      oMemData,
    output logic             oBusy,
    output logic             oDone,
    output logic             oError,
    output logic [CNT_W-1:0] oCount
);

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    op_e               op;
    logic signed [31:0] imm_s;
    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              accept, push, pop;
    logic              fifo_full, fifo_empty;
    logic [31:0]       fifo_rdata;

    assign op     = op_e'(iOp);
    assign imm_s  = iImm;
    assign oReady = (state_q == ST_RUN) && !fifo_full;
    assign accept = iValid && oReady;
    assign push   = accept && enc_ok;
    assign pop    = oMemWrite && iMemReady;

    // Field-to-word encoder plus legality check of op and immediate
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (op)
            OP_ADD:  begin enc_word = {F7_BASE, iRs2, iRs1, F3_ADD_SUB, iRd, OPC_OP}; enc_ok = 1'b1; end
            OP_SUB:  begin enc_word = {F7_SUB,  iRs2, iRs1, F3_ADD_SUB, iRd, OPC_OP}; enc_ok = 1'b1; end
            OP_AND:  begin enc_word = {F7_BASE, iRs2, iRs1, F3_AND,     iRd, OPC_OP}; enc_ok = 1'b1; end
            OP_OR:   begin enc_word = {F7_BASE, iRs2, iRs1, F3_OR,      iRd, OPC_OP}; enc_ok = 1'b1; end
            OP_SLT:  begin enc_word = {F7_BASE, iRs2, iRs1, F3_SLT,     iRd, OPC_OP}; enc_ok = 1'b1; end
            OP_ADDI: begin
                enc_word = {iImm[11:0], iRs1, F3_ADDI, iRd, OPC_OP_IMM};
                enc_ok   = in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            OP_LW: begin
                enc_word = {iImm[11:0], iRs1, F3_LW, iRd, OPC_LOAD};
                enc_ok   = in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            OP_JALR: begin
                enc_word = {iImm[11:0], iRs1, F3_JALR, iRd, OPC_JALR};
                enc_ok   = in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            OP_SW: begin
                enc_word = {iImm[11:5], iRs2, iRs1, F3_SW, iImm[4:0], OPC_STORE};
                enc_ok   = in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            OP_BEQ: begin
                enc_word = {iImm[12], iImm[10:5], iRs2, iRs1, F3_BEQ, iImm[4:1], iImm[11], OPC_BRANCH};
                enc_ok   = in_range(imm_s, IMMB_MIN, IMMB_MAX) && !iImm[0];
            end
            OP_JAL: begin
                enc_word = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, OPC_JAL};
                enc_ok   = in_range(imm_s, IMMJ_MIN, IMMJ_MAX) && !iImm[0];
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // Session control: write-address/count advance on each accepted write, error capture, drain exit
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (pop) begin
            addr_d  = addr_q + 32'd4;
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (accept && !enc_ok) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_RUN;
                    addr_d  = iBaseAddr & 32'hFFFF_FFFC;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (iStop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Loader FSM and its registered status outputs
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    instr_fifo #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCLK),
        .rst   (iRST),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign oMemWrite = !fifo_empty;
    assign oMemData  = fifo_rdata;
    assign oMemAddr  = addr_q;
    assign oBusy     = (state_q != ST_IDLE);
    assign oDone     = done_q;
    assign oError    = err_q;
    assign oCount    = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: expected memory writes are queued
// as bundles are driven and checked as the loader issues them.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    logic        clk = 1'b0;
    logic        iRST, iStart, iStop, iValid, iMemReady;
    logic [31:0] iBaseAddr, iImm;
    logic [3:0]  iOp;
    logic [4:0]  iRd, iRs1, iRs2;
    logic        oReady, oMemWrite, oBusy, oDone, oError;
    logic [31:0] oMemAddr, oMemData;
    logic [15:0] oCount;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] exp_addr;

    instr_encoder_loader #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
        .iCLK(clk), .iRST(iRST), .iStart(iStart), .iBaseAddr(iBaseAddr),
        .iStop(iStop), .iValid(iValid), .oReady(oReady), .iOp(iOp),
        .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm),
        .oMemWrite(oMemWrite), .iMemReady(iMemReady), .oMemAddr(oMemAddr),
        .oMemData(oMemData), .oBusy(oBusy), .oDone(oDone), .oError(oError),
        .oCount(oCount)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge note acceptance and score any write that will complete
    task automatic tick(output logic acc);
        wr_t e;
        @(negedge clk);
        acc = iValid && oReady;
        if (iMemReady && oMemWrite) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_addr", oMemAddr, e.addr);
                chk("wr_data", oMemData, e.data);
            end else begin
                chk("spurious_write", {31'd0, oMemWrite}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick0();
        logic a;
        tick(a);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick0();
    endtask

    task automatic wait_acc(input int max, output logic ok);
        logic a;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(a);
            if (a) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) iValid = 1'b0;
    endtask

    task automatic offer(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        iValid = 1'b1;
        iOp    = op;
        iRd    = rd;
        iRs1   = rs1;
        iRs2   = rs2;
        iImm   = imm;
    endtask

    task automatic send(input string tag, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic legal, input logic [31:0] enc);
        logic ok;
        offer(op, rd, rs1, rs2, imm);
        if (legal) begin
            sb.push_back({exp_addr, enc});
            exp_addr = exp_addr + 32'd4;
        end
        wait_acc(20, ok);
        if (!ok) iValid = 1'b0;
        chk({"accept_", tag}, {31'd0, ok}, 32'd1);
    endtask

    task automatic flush();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            tick0();
        end
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, {31'd0, oReady}, 32'd0);
        chk({tag, "_memwrite"}, {31'd0, oMemWrite}, 32'd0);
        chk({tag, "_addr"}, oMemAddr, 32'd0);
        chk({tag, "_data"}, oMemData, 32'd0);
        chk({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
        chk({tag, "_done"}, {31'd0, oDone}, 32'd0);
        chk({tag, "_error"}, {31'd0, oError}, 32'd0);
        chk({tag, "_count"}, {16'd0, oCount}, 32'd0);
    endtask

    initial begin
        logic ok;
        logic got;
        int   c0;
        iRST = 1'b1; iStart = 1'b0; iStop = 1'b0; iValid = 1'b0; iMemReady = 1'b0;
        iBaseAddr = '0; iImm = '0; iOp = '0; iRd = '0; iRs1 = '0; iRs2 = '0;
        exp_addr = '0;
        ticks(2);
        check_reset("rst");
        iRST = 1'b0;
        iMemReady = 1'b1;
        tick0();

        // Session at 0x400
        iBaseAddr = 32'h0000_0400;
        iStart = 1'b1;
        tick0();
        iStart = 1'b0;
        exp_addr = 32'h0000_0400;
        chk("start_busy", {31'd0, oBusy}, 32'd1);
        chk("start_ready", {31'd0, oReady}, 32'd1);

        send("add", OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
        chk("first_wr_valid", {31'd0, oMemWrite}, 32'd1);
        chk("first_wr_addr", oMemAddr, 32'h0000_0400);
        chk("first_wr_data", oMemData, 32'h0020_81B3);
        tick0();
        chk("count_after_add", {16'd0, oCount}, 32'd1);

        send("addi_m1", OP_ADDI, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0293);
        send("sw", OP_SW, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_A423);
        flush();
        chk("count_after_sw", {16'd0, oCount}, 32'd3);

        // Branch encoding, then bundles that must be dropped
        send("beq_m4", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
        send("beq_odd", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0);
        send("addi_2048", OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b0, 32'd0);
        send("jal_big", OP_JAL, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 1'b0, 32'd0);
        send("op_12", 4'd12, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'd0);
        flush();
        tick0();
        chk("err_sticky", {31'd0, oError}, 32'd1);
        chk("addr_not_advanced", oMemAddr, 32'h0000_0410);
        chk("count_after_illegal", {16'd0, oCount}, 32'd4);
        chk("no_write_pending", {31'd0, oMemWrite}, 32'd0);

        // Remaining ops back to back
        c0 = cyc;
        send("sub", OP_SUB, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h4031_00B3);
        send("and", OP_AND, 5'd7, 5'd5, 5'd6, 32'd0, 1'b1, 32'h0062_F3B3);
        send("or", OP_OR, 5'd4, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_E233);
        send("slt", OP_SLT, 5'd4, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_A233);
        send("lw", OP_LW, 5'd5, 5'd2, 5'd0, 32'd4, 1'b1, 32'h0041_2283);
        send("jal", OP_JAL, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h0080_00EF);
        send("jalr", OP_JALR, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1, 32'h0000_8067);
        chk("throughput_cycles", cyc - c0, 32'd7);
        flush();
        tick0();
        chk("count_after_ops", {16'd0, oCount}, 32'd11);
        chk("addr_after_ops", oMemAddr, 32'h0000_042C);

        // Memory stalls: two bundles fill the buffer, the third waits
        iMemReady = 1'b0;
        send("bp_and", OP_AND, 5'd7, 5'd5, 5'd6, 32'd0, 1'b1, 32'h0062_F3B3);
        send("bp_or", OP_OR, 5'd4, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_E233);
        offer(OP_SUB, 5'd1, 5'd2, 5'd3, 32'd0);
        sb.push_back({exp_addr, 32'h4031_00B3});
        exp_addr = exp_addr + 32'd4;
        wait_acc(5, ok);
        chk("bp_blocked", {31'd0, ok}, 32'd0);
        chk("bp_ready_low", {31'd0, oReady}, 32'd0);
        chk("bp_write_held", {31'd0, oMemWrite}, 32'd1);
        chk("bp_addr_held", oMemAddr, 32'h0000_042C);
        chk("bp_data_held", oMemData, 32'h0062_F3B3);
        iMemReady = 1'b1;
        wait_acc(10, ok);
        if (!ok) iValid = 1'b0;
        chk("bp_third_accepted", {31'd0, ok}, 32'd1);
        flush();
        tick0();
        chk("count_after_bp", {16'd0, oCount}, 32'd14);

        // Stop with two words buffered
        iMemReady = 1'b0;
        send("stop_add", OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
        send("stop_slt", OP_SLT, 5'd4, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_A233);
        iStop = 1'b1;
        tick0();
        iStop = 1'b0;
        chk("drain_busy", {31'd0, oBusy}, 32'd1);
        chk("drain_ready", {31'd0, oReady}, 32'd0);
        iMemReady = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick0();
            if (oDone) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("drain_sb_empty", sb.size(), 32'd0);
        chk("count_at_done", {16'd0, oCount}, 32'd16);
        tick0();
        chk("done_one_cycle", {31'd0, oDone}, 32'd0);
        chk("idle_after_done", {31'd0, oBusy}, 32'd0);

        // Session at the top of the address space: write address wraps to 0
        iBaseAddr = 32'hFFFF_FFFE;
        iStart = 1'b1;
        tick0();
        iStart = 1'b0;
        exp_addr = 32'hFFFF_FFFC;
        chk("s2_err_cleared", {31'd0, oError}, 32'd0);
        chk("s2_count_cleared", {16'd0, oCount}, 32'd0);
        chk("s2_base_aligned", oMemAddr, 32'hFFFF_FFFC);
        send("wrap_addi", OP_ADDI, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0293);
        send("wrap_add", OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
        flush();
        tick0();
        chk("wrap_count", {16'd0, oCount}, 32'd2);
        chk("wrap_addr", oMemAddr, 32'h0000_0004);

        // Reset while draining discards the buffered word
        iMemReady = 1'b0;
        send("rst_lw", OP_LW, 5'd5, 5'd2, 5'd0, 32'd4, 1'b1, 32'h0041_2283);
        iStop = 1'b1;
        tick0();
        iStop = 1'b0;
        chk("pre_rst_busy", {31'd0, oBusy}, 32'd1);
        chk("pre_rst_write", {31'd0, oMemWrite}, 32'd1);
        #2;
        iRST = 1'b1;
        #1;
        check_reset("midrst");
        sb.delete();
        iMemReady = 1'b1;
        ticks(2);
        iRST = 1'b0;
        ticks(3);
        chk("post_rst_idle", {31'd0, oBusy}, 32'd0);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
